// File: rtl/msad_tracker.sv
// Block-level MSAD tracker: folds one per-row minimum per beat into a running
// block minimum and presents the result through a valid/ready output register.
module msad_tracker #(
  parameter int SAD_BIT_WIDTH      = 14,
  parameter int CANDIDATES_PER_ROW = 16,
  parameter int ROWS               = 16,
  parameter int INDEX_WIDTH        = 4,
  parameter int ROW_WIDTH          = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SAD_BIT_WIDTH-1:0] in_sad,
  input  logic [INDEX_WIDTH-1:0]   in_index,
  input  logic                     in_first,
  input  logic                     thr_en,
  input  logic [SAD_BIT_WIDTH-1:0] thr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SAD_BIT_WIDTH-1:0] out_sad,
  output logic [INDEX_WIDTH-1:0]   out_col,
  output logic [ROW_WIDTH-1:0]     out_row,
  output logic [INDEX_WIDTH:0]     out_mvx,
  output logic [ROW_WIDTH:0]       out_mvy,
  output logic                     out_early,
  output logic                     err_resync
);

  localparam logic [ROW_WIDTH-1:0] LAST_ROW = ROW_WIDTH'(ROWS - 1);
  localparam logic [INDEX_WIDTH:0] MVX_OFS  = (INDEX_WIDTH + 1)'(CANDIDATES_PER_ROW / 2);
  localparam logic [ROW_WIDTH:0]   MVY_OFS  = (ROW_WIDTH + 1)'(ROWS / 2);

  typedef enum logic {ACC = 1'b0, STALL = 1'b1} state_t;

  state_t                   r_state;
  logic [ROW_WIDTH-1:0]     r_row_cnt;
  logic [SAD_BIT_WIDTH-1:0] r_best_sad, r_pend_sad, r_out_sad;
  logic [INDEX_WIDTH-1:0]   r_best_col, r_pend_col, r_out_col;
  logic [ROW_WIDTH-1:0]     r_best_row, r_pend_row, r_out_row;
  logic                     r_early_acc, r_pend_early, r_out_early;
  logic                     r_out_valid;
  logic                     r_err_resync;

  logic                     w_accept, w_start, w_last, w_take, w_out_free;
  logic [ROW_WIDTH-1:0]     w_beat_row;
  logic [SAD_BIT_WIDTH-1:0] w_best_sad;
  logic [INDEX_WIDTH-1:0]   w_best_col;
  logic [ROW_WIDTH-1:0]     w_best_row;
  logic                     w_best_early;

  assign in_ready   = (r_state == ACC);
  assign w_accept   = in_valid && in_ready;
  assign w_start    = (r_row_cnt == '0) || in_first;
  assign w_beat_row = w_start ? '0 : r_row_cnt;
  assign w_last     = (w_beat_row == LAST_ROW);
  assign w_take     = r_out_valid && out_ready;
  assign w_out_free = !r_out_valid || out_ready;

  // Running best including the current beat; the early flag looks at the post-update best.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_best_sad   = r_best_sad;
    w_best_col   = r_best_col;
    w_best_row   = r_best_row;
    w_best_early = r_early_acc;
    if (w_start) begin
      w_best_sad   = in_sad;
      w_best_col   = in_index;
      w_best_row   = '0;
      w_best_early = 1'b0;
    end else if (in_sad < r_best_sad) begin
      w_best_sad = in_sad;
      w_best_col = in_index;
      w_best_row = r_row_cnt;
    end
    w_best_early = w_best_early | (thr_en && (w_best_sad <= thr));
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      r_state      <= ACC;
      r_row_cnt    <= '0;
      r_best_sad   <= '0;
      r_best_col   <= '0;
      r_best_row   <= '0;
      r_early_acc  <= 1'b0;
      r_pend_sad   <= '0;
      r_pend_col   <= '0;
      r_pend_row   <= '0;
      r_pend_early <= 1'b0;
      r_out_sad    <= '0;
      r_out_col    <= '0;
      r_out_row    <= '0;
      r_out_early  <= 1'b0;
      r_out_valid  <= 1'b0;
      r_err_resync <= 1'b0;
    end else begin
      if (w_take) r_out_valid <= 1'b0;
      case (r_state)
        ACC: begin
          if (w_accept) begin
            if (in_first && (r_row_cnt != '0)) r_err_resync <= 1'b1;
            if (w_last) begin
              r_row_cnt <= '0;
              if (w_out_free) begin
                r_out_sad   <= w_best_sad;
                r_out_col   <= w_best_col;
                r_out_row   <= w_best_row;
                r_out_early <= w_best_early;
                r_out_valid <= 1'b1;
              end else begin
                r_pend_sad   <= w_best_sad;
                r_pend_col   <= w_best_col;
                r_pend_row   <= w_best_row;
                r_pend_early <= w_best_early;
                r_state      <= STALL;
              end
            end else begin
              r_row_cnt   <= w_beat_row + ROW_WIDTH'(1);
              r_best_sad  <= w_best_sad;
              r_best_col  <= w_best_col;
              r_best_row  <= w_best_row;
              r_early_acc <= w_best_early;
            end
          end
        end
        STALL: begin
          if (w_take) begin
            r_out_sad   <= r_pend_sad;
            r_out_col   <= r_pend_col;
            r_out_row   <= r_pend_row;
            r_out_early <= r_pend_early;
            r_out_valid <= 1'b1;
            r_state     <= ACC;
          end
        end
        default: r_state <= ACC;
      endcase
    end
  end

  assign out_valid  = r_out_valid;
  assign out_sad    = r_out_sad;
  assign out_col    = r_out_col;
  assign out_row    = r_out_row;
  assign out_early  = r_out_early;
  assign err_resync = r_err_resync;
  assign out_mvx    = {1'b0, r_out_col} - MVX_OFS;
  assign out_mvy    = {1'b0, r_out_row} - MVY_OFS;

endmodule

// File: tb/tb_msad_tracker.sv
// Randomized and directed bench for msad_tracker against a block-level
// reference model (beat lists reduced to a result queue).
module tb_msad_tracker;

  localparam int SW = 14;
  localparam int C  = 16;
  localparam int R  = 16;
  localparam int IW = 4;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [SW-1:0] in_sad = '0;
  logic [IW-1:0] in_index = '0;
  logic          in_first = 1'b0;
  logic          thr_en = 1'b0;
  logic [SW-1:0] thr = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [SW-1:0] out_sad;
  logic [IW-1:0] out_col;
  logic [RW-1:0] out_row;
  logic [IW:0]   out_mvx;
  logic [RW:0]   out_mvy;
  logic          out_early;
  logic          err_resync;

  msad_tracker #(
    .SAD_BIT_WIDTH(SW), .CANDIDATES_PER_ROW(C), .ROWS(R),
    .INDEX_WIDTH(IW), .ROW_WIDTH(RW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sad(in_sad),
    .in_index(in_index), .in_first(in_first), .thr_en(thr_en), .thr(thr),
    .out_valid(out_valid), .out_ready(out_ready), .out_sad(out_sad),
    .out_col(out_col), .out_row(out_row), .out_mvx(out_mvx),
    .out_mvy(out_mvy), .out_early(out_early), .err_resync(err_resync)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sad;
    int col;
    int row;
    bit early;
  } res_t;

  // Reference model: beats of the open block, results not yet taken, sticky error.
  int   b_sad[$];
  int   b_idx[$];
  int   b_thr[$];
  bit   b_ten[$];
  res_t exp_q[$];
  bit   exp_err;

  int   n_checks = 0;
  int   n_errors = 0;
  bit   last_acc;
  bit   rand_ready = 1'b0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic res_t block_result();
    res_t r;
    r.sad   = b_sad[0];
    r.col   = b_idx[0];
    r.row   = 0;
    r.early = 1'b0;
    for (int i = 0; i < b_sad.size(); i++) begin
      if (b_sad[i] < r.sad) begin
        r.sad = b_sad[i];
        r.col = b_idx[i];
        r.row = i;
      end
      if (b_ten[i] && (r.sad <= b_thr[i])) r.early = 1'b1;
    end
    return r;
  endfunction

  task automatic model_beat();
    if (in_first || b_sad.size() == 0) begin
      if (in_first && b_sad.size() != 0) exp_err = 1'b1;
      b_sad.delete(); b_idx.delete(); b_thr.delete(); b_ten.delete();
    end
    b_sad.push_back(int'(in_sad));
    b_idx.push_back(int'(in_index));
    b_thr.push_back(int'(thr));
    b_ten.push_back(thr_en);
    if (b_sad.size() == R) begin
      exp_q.push_back(block_result());
      b_sad.delete(); b_idx.delete(); b_thr.delete(); b_ten.delete();
    end
  endtask

  task automatic model_clear();
    b_sad.delete(); b_idx.delete(); b_thr.delete(); b_ten.delete();
    exp_q.delete();
    exp_err = 1'b0;
  endtask

  // One clock: compare against the model, predict the edge, advance both.
  task automatic tick();
    bit exp_in_ready;
    bit take;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    exp_in_ready = (exp_q.size() < 2);
    check("in_ready", longint'(in_ready), longint'(exp_in_ready));
    check("out_valid", longint'(out_valid), longint'(exp_q.size() > 0));
    check("err_resync", longint'(err_resync), longint'(exp_err));
    if (exp_q.size() > 0) begin
      check("out_sad", longint'(out_sad), longint'(exp_q[0].sad));
      check("out_col", longint'(out_col), longint'(exp_q[0].col));
      check("out_row", longint'(out_row), longint'(exp_q[0].row));
      check("out_mvx", longint'($signed(out_mvx)), longint'(exp_q[0].col - C / 2));
      check("out_mvy", longint'($signed(out_mvy)), longint'(exp_q[0].row - R / 2));
      check("out_early", longint'(out_early), longint'(exp_q[0].early));
    end
    last_acc = in_valid && exp_in_ready;
    take = (exp_q.size() > 0) && out_ready;
    if (take) void'(exp_q.pop_front());
    if (last_acc) model_beat();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic send_beat(input int sad, input int idx, input bit first);
    in_valid = 1'b1;
    in_sad   = SW'(sad);
    in_index = IW'(idx);
    in_first = first;
    last_acc = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (last_acc) break;
    end
    if (!last_acc) check("accept_timeout", 0, 1);
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_first = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    model_clear();
    do_reset();
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_sad", longint'(out_sad), 0);

    // Descending SADs: last row wins.
    out_ready = 1'b1;
    for (int r = 0; r < R; r++) send_beat(100 - r, r % C, r == 0);
    check("t1_valid", longint'(out_valid), 1);
    check("t1_sad", longint'(out_sad), 85);
    check("t1_col", longint'(out_col), 15);
    check("t1_row", longint'(out_row), 15);
    check("t1_mvx", longint'($signed(out_mvx)), 7);
    check("t1_mvy", longint'($signed(out_mvy)), 7);
    idle(2);

    // All ties: earliest row kept.
    for (int r = 0; r < R; r++) send_beat(50, 3, r == 0);
    check("tie_row", longint'(out_row), 0);
    check("tie_col", longint'(out_col), 3);
    check("tie_mvx", longint'($signed(out_mvx)), -5);
    check("tie_mvy", longint'($signed(out_mvy)), -8);
    idle(2);

    // Back-pressure: two blocks queue up, tracker stalls.
    out_ready = 1'b0;
    for (int r = 0; r < R; r++) send_beat(300 - r, r, r == 0);
    for (int r = 0; r < R; r++) send_beat(40 + r, (r + 2) % C, r == 0);
    check("bp_in_ready", longint'(in_ready), 0);
    check("bp_hold_sad", longint'(out_sad), 285);
    idle(3);
    check("bp_still_sad", longint'(out_sad), 285);
    out_ready = 1'b1;
    idle(1);
    check("bp_blk2_valid", longint'(out_valid), 1);
    check("bp_blk2_sad", longint'(out_sad), 40);
    check("bp_blk2_col", longint'(out_col), 2);
    check("bp_in_ready_back", longint'(in_ready), 1);
    idle(2);

    // Threshold flag with and without enable.
    thr = SW'(20);
    for (int pass = 0; pass < 2; pass++) begin
      thr_en = (pass == 0);
      for (int r = 0; r < R; r++) send_beat((r == 6) ? 15 : 100, r, r == 0);
      check("thr_early", longint'(out_early), longint'(pass == 0));
      check("thr_row", longint'(out_row), 6);
      idle(1);
    end
    thr_en = 1'b0;

    // Resync at row 9: partial block of tiny SADs must be dropped.
    for (int r = 0; r < 9; r++) send_beat(1, 0, r == 0);
    for (int r = 0; r < R; r++) send_beat(500 - 3 * r, (r * 5) % C, r == 0);
    check("rs_err", longint'(err_resync), 1);
    check("rs_sad", longint'(out_sad), 455);
    check("rs_col", longint'(out_col), 11);
    idle(3);
    check("rs_err_sticky", longint'(err_resync), 1);

    // Reset while stalled drops everything.
    out_ready = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < R; r++) send_beat(200 + r, r, r == 0);
    check("st_in_ready", longint'(in_ready), 0);
    do_reset();
    check("rst2_in_ready", longint'(in_ready), 1);
    check("rst2_out_valid", longint'(out_valid), 0);
    check("rst2_out_sad", longint'(out_sad), 0);
    check("rst2_out_col", longint'(out_col), 0);
    check("rst2_out_row", longint'(out_row), 0);
    check("rst2_early", longint'(out_early), 0);
    check("rst2_err", longint'(err_resync), 0);
    out_ready = 1'b1;
    idle(4);

    // Randomized traffic: gaps, random ready, thresholds, occasional resync.
    rand_ready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      for (int r = 0; r < R; r++) begin
        thr_en = 1'($urandom_range(0, 1));
        thr    = SW'($urandom_range(0, 400));
        send_beat($urandom_range(0, 1000), $urandom_range(0, C - 1),
                  (r == 0) || ($urandom_range(0, 40) == 0));
        if ($urandom_range(0, 3) == 0) idle(1);
      end
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    idle(6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/msad_tracker.md
Name: msad_tracker

Overview:
- Parametrised successor to the single-block MSAD post-processing stage.
- Consumes one per-row interim minimum per cycle (SAD plus candidate index) from the MIN tree and tracks the running minimum over ROWS search rows.
- Emits the block-level best SAD, column and row, plus a signed motion vector, through a valid/ready output register.
- Adds an input back-pressure handshake, an early-termination threshold flag, a mid-block resync with a sticky error, and a configurable search geometry.

Parameters:
- SAD_BIT_WIDTH, 14, width of the SAD values.
- CANDIDATES_PER_ROW, 16, candidates per search row; in_index range is 0..CANDIDATES_PER_ROW-1.
- ROWS, 16, search rows per block.
- INDEX_WIDTH, 4, equals clog2(CANDIDATES_PER_ROW).
- ROW_WIDTH, 5, equals clog2(ROWS)+1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  row beat valid.
- in_ready  out  1  tracker accepts a beat this cycle.
- in_sad  in  SAD_BIT_WIDTH  row minimum SAD.
- in_index  in  INDEX_WIDTH  column of the row minimum.
- in_first  in  1  beat is row 0 of a new block.
- thr_en  in  1  enable the early-termination compare.
- thr  in  SAD_BIT_WIDTH  early-termination threshold.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sad  out  SAD_BIT_WIDTH  block minimum SAD.
- out_col  out  INDEX_WIDTH  column of the minimum.
- out_row  out  ROW_WIDTH  row of the minimum.
- out_mvx  out  INDEX_WIDTH+1  signed out_col - CANDIDATES_PER_ROW/2.
- out_mvy  out  ROW_WIDTH+1  signed out_row - ROWS/2.
- out_early  out  1  best SAD <= thr while thr_en was high.
- err_resync  out  1  sticky error: block restarted before completion.

Behaviour:
- Handshakes:
  - A beat is accepted when in_valid && in_ready.
  - A result is taken when out_valid && out_ready.
- Reset values: every output and internal register clears to 0; state = ACC; row_cnt = 0; in_ready = 1 on the first cycle after reset.
- State ACC:
  - in_ready = 1.
  - Row 0 (row_cnt == 0, or in_first == 1): best_sad = in_sad, best_col = in_index, best_row = 0, row_cnt = 1.
  - Later rows: update best only when in_sad < best_sad (strict). On ties the earlier row is kept; within a row, upstream index order decides.
  - Early flag: early_acc |= thr_en && (candidate SAD <= thr), evaluated on each accepted beat against the post-update best. It is cleared at row 0.
- Resync: in_first accepted while row_cnt != 0 discards the partial block, restarts at row 0 and sets err_resync. err_resync clears only on rst.
- Block completion (beat with row_cnt == ROWS-1 accepted):
  - If the output register is free (!out_valid, or out_ready this cycle), the result, including the final beat's contribution, loads next cycle: out_valid = 1 one cycle after the last beat. State stays ACC and row_cnt = 0.
  - Otherwise the result is held in a pending register; state goes to STALL.
- State STALL:
  - in_ready = 0 and beats are ignored.
  - On out_valid && out_ready, pending loads into the output register next cycle, out_valid stays 1, and state returns to ACC.
- Output register is stable while out_valid && !out_ready; out_valid drops the cycle after a take unless a new result loads.
- Throughput: one block per ROWS cycles with out_ready held high; no bubble between blocks.
- Arithmetic:
  - Compares are unsigned.
  - out_mvx and out_mvy are two's complement, computed combinationally from the registered col/row.
- ROWS = 1: every accepted beat completes a block.
- rst mid-block or mid-STALL drops all partial and pending data.

Test Plan:
- Defaults, out_ready = 1, 16 beats: sad = 100 - r, index = r%16 for r = 0..15 -> out_valid one cycle after beat 15; out_sad = 85, out_col = 15, out_row = 15, out_mvx = 7, out_mvy = 7.
- Ties: all 16 beats sad = 50, index = 3 -> out_row = 0, out_col = 3, out_mvx = -5, out_mvy = -8.
- Back-pressure: out_ready = 0, two full blocks sent -> after block 2's last beat in_ready = 0 and block 1 is held stable. Raise out_ready -> block 1 taken, block 2 appears the next cycle, in_ready returns to 1.
- Threshold: thr_en = 1, thr = 20, one beat sad = 15 at row 6 -> out_early = 1. Same stream with thr_en = 0 -> out_early = 0.
- Resync: in_first asserted at row 9 of a block -> err_resync = 1 and sticky. The next result reflects only the 16 beats from the restart.
- Reset: rst asserted for 1 cycle during STALL -> all outputs 0, in_ready = 1 the next cycle, no stale result emitted.
